six_step_commutator: RTL and testbench

- Upstream command generator for the h_bridge stage.
- Produces the three half-bridge switch commands (sw1, sw2, sw3) as a six-step commutation sequence, chopped by a duty-cycle PWM.
- Produces the watchdog level consumed by the bridge. It is driven high only while a host keep-alive toggles within a timeout.
- Replaces the free-running counter test pattern in front of the bridge.

---
 rtl/six_step_commutator.sv | 200 ++++++++++++++++++++
 tb/tb_six_step_commutator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/six_step_commutator.sv
// six_step_commutator: six-step commutation with PWM chopping, a kick watchdog and a latched timeout fault.
// Outputs are registered one clk after the counter state; no flow control. SIX_STEP_SOFT_START_EN adds a duty ramp.
module six_step_commutator #(
  parameter int PWM_BITS   = 8,
  parameter int TICK_DIV   = 25000,
  parameter int WD_TIMEOUT = 5000000
`ifdef SIX_STEP_SOFT_START_EN
  , parameter int RAMP_DIV = 50000
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                dir,
  input  logic [15:0]         step_period,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                wd_kick,
  output logic                sw1,
  output logic                sw2,
  output logic                sw3,
  output logic                watchdog,
  output logic [2:0]          step_idx,
  output logic                fault
);
  localparam int WDW = $clog2(WD_TIMEOUT + 1);
  localparam int TKW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [WDW-1:0] WD_MAX   = WDW'(WD_TIMEOUT);
  localparam logic [TKW-1:0] TICK_MAX = TKW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_e;

  state_e              state_q, state_d;
  logic                kick_s1_q, kick_s2_q, kick_s3_q;
  logic                kick_edge, timeout, run, tick, pwm_on;
  logic [WDW-1:0]      wd_cnt_q, wd_cnt_d;
  logic [TKW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [15:0]         step_cnt_q, step_cnt_d;
  logic [2:0]          step_idx_q, step_idx_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d, duty_eff, duty_cmp;
  logic [2:0]          sw_q, sw_d;
  logic                watchdog_q, watchdog_d;
  logic                fault_q, fault_d;

  function automatic logic [2:0] step_pattern(input logic [2:0] idx);
    case (idx)
      3'd0:    step_pattern = 3'b100;
      3'd1:    step_pattern = 3'b110;
      3'd2:    step_pattern = 3'b010;
      3'd3:    step_pattern = 3'b011;
      3'd4:    step_pattern = 3'b001;
      3'd5:    step_pattern = 3'b101;
      default: step_pattern = 3'b000;
    endcase
  endfunction

  assign run       = (state_q == RUN);
  assign kick_edge = kick_s2_q ^ kick_s3_q;
  assign tick      = run && (tick_cnt_q == TICK_MAX);

  // Watchdog count only advances in RUN, so entering RUN always starts from zero.
  always_comb begin
    wd_cnt_d = '0;
    if (run && !kick_edge) begin
      wd_cnt_d = (wd_cnt_q == WD_MAX) ? WD_MAX : wd_cnt_q + 1'b1;
    end
  end
  assign timeout = run && (wd_cnt_d == WD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
               else if (timeout) state_d = FAULT;
      FAULT:   if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_cnt_d = '0;
    pwm_cnt_d  = '0;
    if (run) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      pwm_cnt_d  = pwm_cnt_q + 1'b1;
    end
  end

  // A period that starts this cycle already compares against the freshly sampled duty.
  assign duty_eff = (pwm_cnt_q == '0) ? duty : duty_q;
  always_comb begin
    duty_d = duty_q;
    if (pwm_cnt_q == '0) duty_d = duty;
  end

  always_comb begin
    step_cnt_d = step_cnt_q;
    step_idx_d = step_idx_q;
    if (!run || step_period == 16'd0) begin
      step_cnt_d = '0;
    end else if (tick) begin
      if (step_cnt_q >= step_period - 16'd1) begin
        step_cnt_d = '0;
        if (dir) step_idx_d = (step_idx_q == 3'd5) ? 3'd0 : step_idx_q + 3'd1;
        else     step_idx_d = (step_idx_q == 3'd0) ? 3'd5 : step_idx_q - 3'd1;
      end else begin
        step_cnt_d = step_cnt_q + 16'd1;
      end
    end
  end

`ifdef SIX_STEP_SOFT_START_EN
  localparam int RDW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RDW-1:0] RAMP_MAX = RDW'(RAMP_DIV - 1);
  logic [RDW-1:0]      ramp_div_q, ramp_div_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d;

  always_comb begin
    ramp_div_d = '0;
    ramp_d     = '0;
    if (run) begin
      ramp_d = ramp_q;
      if (ramp_div_q == RAMP_MAX) begin
        ramp_div_d = '0;
        if (ramp_q != '1) ramp_d = ramp_q + 1'b1;
      end else begin
        ramp_div_d = ramp_div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_div_q <= '0;
      ramp_q     <= '0;
    end else begin
      ramp_div_q <= ramp_div_d;
      ramp_q     <= ramp_d;
    end
  end

  assign duty_cmp = (ramp_q < duty_eff) ? ramp_q : duty_eff;
`else
  assign duty_cmp = duty_eff;
`endif

  assign pwm_on = (pwm_cnt_q < duty_cmp);

  // Output decode: commands are only live while RUN is both current and next state.
  always_comb begin
    sw_d       = 3'b000;
    watchdog_d = (state_d == RUN);
    fault_d    = (state_d == FAULT);
    if (run && state_d == RUN && pwm_on) sw_d = step_pattern(step_idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kick_s1_q  <= 1'b0;
      kick_s2_q  <= 1'b0;
      kick_s3_q  <= 1'b0;
      wd_cnt_q   <= '0;
      tick_cnt_q <= '0;
      step_cnt_q <= '0;
      step_idx_q <= '0;
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
      sw_q       <= 3'b000;
      watchdog_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      kick_s1_q  <= wd_kick;
      kick_s2_q  <= kick_s1_q;
      kick_s3_q  <= kick_s2_q;
      wd_cnt_q   <= wd_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      step_cnt_q <= step_cnt_d;
      step_idx_q <= step_idx_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_q     <= duty_d;
      sw_q       <= sw_d;
      watchdog_q <= watchdog_d;
      fault_q    <= fault_d;
    end
  end

  assign {sw1, sw2, sw3} = sw_q;
  assign watchdog        = watchdog_q;
  assign fault           = fault_q;
  assign step_idx        = step_idx_q;
endmodule

// File: tb/tb_six_step_commutator.sv
// Bench for six_step_commutator: directed phases plus random duty/period/direction segments against a reference model.
module tb_six_step_commutator;
  localparam int TICK_DIV   = 4;
  localparam int WD_TIMEOUT = 1000;
`ifdef SIX_STEP_SOFT_START_EN
  localparam int RAMP_DIV   = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n, enable, dir, wd_kick;
  logic [15:0] step_period;
  logic [7:0]  duty;
  logic        sw1, sw2, sw3, watchdog, fault;
  logic [2:0]  step_idx;

  always #5 clk = ~clk;

  six_step_commutator #(
    .PWM_BITS(8), .TICK_DIV(TICK_DIV), .WD_TIMEOUT(WD_TIMEOUT)
`ifdef SIX_STEP_SOFT_START_EN
    , .RAMP_DIV(RAMP_DIV)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dir(dir), .step_period(step_period),
    .duty(duty), .wd_kick(wd_kick), .sw1(sw1), .sw2(sw2), .sw3(sw3),
    .watchdog(watchdog), .step_idx(step_idx), .fault(fault)
  );

  logic [2:0] PAT [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

  int checks = 0;
  int errors = 0;
  // Reference model: t is the number of clocks spent in RUN since entry.
  bit         m_run = 0;
  int         t = 0, m_idx = 0, m_scnt = 0, m_dq = 0;
  logic [2:0] m_sw = 3'b000;
  bit         kicks_on = 0;
  int         since_kick = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int pwm, d, r;
    pwm = t % 256;
    d = (pwm == 0) ? int'(duty) : m_dq;
    if (pwm == 0) m_dq = int'(duty);
`ifdef SIX_STEP_SOFT_START_EN
    r = t / RAMP_DIV;
    if (r > 255) r = 255;
    if (r < d) d = r;
`else
    r = 0;
`endif
    m_sw = (pwm < d) ? PAT[m_idx] : 3'b000;
    if (step_period == 16'd0) m_scnt = 0;
    else if (t % TICK_DIV == TICK_DIV - 1) begin
      if (m_scnt >= int'(step_period) - 1) begin
        m_scnt = 0;
        m_idx = dir ? (m_idx + 1) % 6 : (m_idx + 5) % 6;
      end else m_scnt++;
    end
    t++;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (m_run) model_edge();
    @(negedge clk);
    if (kicks_on) begin
      since_kick++;
      if (since_kick >= 400) begin
        wd_kick = ~wd_kick;
        since_kick = 0;
      end
    end
  endtask

  task automatic check_run(input string tag);
    chk({tag, ".sw"}, {29'd0, sw1, sw2, sw3}, {29'd0, m_sw});
    chk({tag, ".step_idx"}, {29'd0, step_idx}, m_idx);
    chk({tag, ".watchdog"}, {31'd0, watchdog}, 1);
    chk({tag, ".fault"}, {31'd0, fault}, 0);
  endtask

  task automatic check_off(input string tag, input int exp_fault);
    chk({tag, ".sw"}, {29'd0, sw1, sw2, sw3}, 0);
    chk({tag, ".step_idx"}, {29'd0, step_idx}, m_idx);
    chk({tag, ".watchdog"}, {31'd0, watchdog}, 0);
    chk({tag, ".fault"}, {31'd0, fault}, exp_fault);
  endtask

  task automatic run_n(input string tag, input int n);
    repeat (n) begin
      cyc();
      check_run(tag);
    end
  endtask

  task automatic start_run();
    enable = 1'b1;
    @(posedge clk);
    m_run = 1; t = 0; m_scnt = 0; m_sw = 3'b000;
    @(negedge clk);
    check_run("entry");
  endtask

  task automatic stop_run(input string tag);
    enable = 1'b0;
    @(posedge clk);
    model_edge();
    m_run = 0; m_sw = 3'b000;
    @(negedge clk);
    check_off(tag, 0);
  endtask

  initial begin
    int n, cnt, saved, k;
    rst_n = 1'b0; enable = 1'b0; dir = 1'b1; step_period = 16'd2; duty = 8'd255; wd_kick = 1'b0;
    repeat (3) @(negedge clk);
    check_off("reset", 0);
    rst_n = 1'b1;
    repeat (20000) begin
      cyc();
      check_off("idle", 0);
    end

    // Forward sequence at full duty, period 2 ticks of 4 clk.
    kicks_on = 1;
    start_run();
    run_n("fwd", 400);

    // Reverse from step 0 lands on step 5.
    for (int i = 0; i < 100 && m_idx != 0; i++) begin
      cyc();
      check_run("to0");
    end
    dir = 1'b0;
    k = 0;
    while (step_idx == 3'd0 && k < 20) begin
      cyc();
      check_run("rev");
      k++;
    end
    chk("rev_0_to_5", {29'd0, step_idx}, 5);
    run_n("rev", 100);

    // Period 0 freezes the step.
    step_period = 16'd0;
    saved = int'(step_idx);
    run_n("hold", 1000);
    chk("hold_frozen", {29'd0, step_idx}, saved);

    // Quarter duty and mid-period duty change.
    step_period = 16'd1; dir = 1'b1; duty = 8'd64;
    run_n("d64", 300);
`ifndef SIX_STEP_SOFT_START_EN
    cnt = 0;
    repeat (256) begin
      cyc();
      if ({sw1, sw2, sw3} != 3'b000) cnt++;
    end
    chk("duty64_on_count", cnt, 64);
`else
    cnt = 0;
`endif
    k = 0;
    while (t % 256 != 100 && k < 300) begin
      cyc();
      check_run("d64b");
      k++;
    end
    duty = 8'd128;
    run_n("d128", 600);

    // Randomised duty, period (including lowering below the count) and direction.
    for (int s = 0; s < 8; s++) begin
      duty = 8'($urandom_range(0, 255));
      step_period = 16'($urandom_range(0, 3));
      dir = 1'($urandom_range(0, 1));
      run_n("rand", $urandom_range(150, 500));
    end

    // Leave and re-enter RUN: step_idx is held across IDLE.
    stop_run("stop");
    repeat (50) begin
      cyc();
      check_off("idle2", 0);
    end
    step_period = 16'd1; duty = 8'd200;
    start_run();
    run_n("rerun", 300);

    // Asynchronous reset mid-run.
    #2 rst_n = 1'b0;
    #1;
    m_run = 0; m_idx = 0; m_sw = 3'b000;
    check_off("async_rst", 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_run();
    since_kick = 0;
    run_n("post_rst", 200);

    // Watchdog timeout after kicks stop.
    kicks_on = 0;
    cyc();
    check_run("prekick");
    wd_kick = ~wd_kick;
    n = 0;
    while (n < 1100) begin
      cyc();
      n++;
      if (fault === 1'b1) break;
      check_run("wd_wait");
    end
    m_run = 0;
    chk("wd_latency_in_window", {31'd0, (n >= 1001 && n <= 1005)}, 1);
    check_off("wd_fault", 1);

    // Kicks resuming do not recover; enable low clears the fault.
    repeat (5) begin
      wd_kick = ~wd_kick;
      repeat (20) cyc();
    end
    check_off("fault_kicks", 1);
    enable = 1'b0;
    cyc();
    check_off("fault_clear", 0);
    start_run();
    kicks_on = 1; since_kick = 0;
    run_n("recover", 100);

    // Timeout coinciding with enable falling goes to IDLE with no fault.
    kicks_on = 0;
    cyc();
    check_run("prekick2");
    wd_kick = ~wd_kick;
    repeat (n - 1) begin
      cyc();
      check_run("sim_wait");
    end
    stop_run("sim_stop");
    repeat (10) begin
      cyc();
      check_off("sim_after", 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
